// File: rtl/video_timing_pkg.sv
// VGA 640x480@60 raster constants, FSM state type and colour-bar palette
// shared by video_stream_source and video_timing_counter.
package video_timing_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      3'd7:    c = BAR_BLACK;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Free-running h/v raster counters with combinational active area and
// raw (active-high) sync windows decoded from the current count.
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter logic [9:0] H_ACT_W  = H_ACTIVE,
  parameter logic [9:0] H_FP_W   = H_FP,
  parameter logic [9:0] H_SYNC_W = H_SYNC,
  parameter logic [9:0] H_TOT_W  = H_TOTAL,
  parameter logic [9:0] V_ACT_W  = V_ACTIVE,
  parameter logic [9:0] V_FP_W   = V_FP,
  parameter logic [9:0] V_SYNC_W = V_SYNC,
  parameter logic [9:0] V_TOT_W  = V_TOTAL
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       active_o,
  output logic       hs_raw_o,
  output logic       vs_raw_o
);

  localparam logic [9:0] HS_START = H_ACT_W + H_FP_W;
  localparam logic [9:0] HS_END   = HS_START + H_SYNC_W;
  localparam logic [9:0] VS_START = V_ACT_W + V_FP_W;
  localparam logic [9:0] VS_END   = VS_START + V_SYNC_W;

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  // next raster position: h wraps at end of line and advances v
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_TOT_W - 10'd1) begin
      h_d = 10'd0;
      if (v_q == V_TOT_W - 10'd1) begin
        v_d = 10'd0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end else begin
      v_d = v_q;
    end
  end

  // counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o  = h_q;
  assign v_cnt_o  = v_q;
  assign active_o = (h_q < H_ACT_W) && (v_q < V_ACT_W);
  assign hs_raw_o = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_raw_o = (v_q >= VS_START) && (v_q < VS_END);

endmodule

// File: rtl/video_stream_source.sv
// AXI-Stream pixel feeder producing registered VGA RGB/blank/sync with frame
// re-alignment on tlast. Optional colour bars under VIDEO_TEST_PATTERN_EN.
module video_stream_source
  import video_timing_pkg::*;
#(
  parameter logic       HS_POL   = 1'b0,
  parameter logic       VS_POL   = 1'b0,
  parameter logic [9:0] H_ACT_W  = H_ACTIVE,
  parameter logic [9:0] H_FP_W   = H_FP,
  parameter logic [9:0] H_SYNC_W = H_SYNC,
  parameter logic [9:0] H_BP_W   = H_BP,
  parameter logic [9:0] V_ACT_W  = V_ACTIVE,
  parameter logic [9:0] V_FP_W   = V_FP,
  parameter logic [9:0] V_SYNC_W = V_SYNC,
  parameter logic [9:0] V_BP_W   = V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic        pattern_en,
`endif
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        underflow,
  output logic        frame_err
);

  localparam logic [9:0] H_TOT_W = H_ACT_W + H_FP_W + H_SYNC_W + H_BP_W;
  localparam logic [9:0] V_TOT_W = V_ACT_W + V_FP_W + V_SYNC_W + V_BP_W;

  logic [9:0]  h_cnt_s, v_cnt_s;
  logic        active_s, hs_raw_s, vs_raw_s;
  logic        last_px_s, frame_wrap_s, tready_s, handshake_s;
  state_e      state_q, state_d, fsm_nxt_s;
  logic [23:0] stream_rgb_s, rgb_q, rgb_d;
  logic        stream_uf_s, stream_fe_s;
  logic        underflow_q, underflow_d, frame_err_q, frame_err_d;
  logic        blank_q, hsync_q, vsync_q;

  video_timing_counter #(
    .H_ACT_W (H_ACT_W),
    .H_FP_W  (H_FP_W),
    .H_SYNC_W(H_SYNC_W),
    .H_TOT_W (H_TOT_W),
    .V_ACT_W (V_ACT_W),
    .V_FP_W  (V_FP_W),
    .V_SYNC_W(V_SYNC_W),
    .V_TOT_W (V_TOT_W)
  ) u_timing (
    .clk_i   (clk),
    .rst_i   (rst),
    .h_cnt_o (h_cnt_s),
    .v_cnt_o (v_cnt_s),
    .active_o(active_s),
    .hs_raw_o(hs_raw_s),
    .vs_raw_o(vs_raw_s)
  );

  assign last_px_s    = (h_cnt_s == H_ACT_W - 10'd1) && (v_cnt_s == V_ACT_W - 10'd1);
  assign frame_wrap_s = (h_cnt_s == H_TOT_W - 10'd1) && (v_cnt_s == V_TOT_W - 10'd1);
  assign handshake_s  = s_axis_tvalid && tready_s;

  // ready depends only on raster position and FSM state
  always_comb begin
    tready_s = 1'b0;
    if (rst) begin
      tready_s = 1'b0;
`ifdef VIDEO_TEST_PATTERN_EN
    end else if (pattern_en) begin
      tready_s = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_RUN:   tready_s = active_s;
        ST_FLUSH: tready_s = 1'b1;
        ST_WAIT:  tready_s = 1'b0;
        default:  tready_s = 1'b0;
      endcase
    end
  end

  assign s_axis_tready = tready_s;

  // stream FSM; in RUN during active, handshake is simply tvalid
  always_comb begin
    fsm_nxt_s    = state_q;
    stream_rgb_s = 24'h000000;
    stream_uf_s  = 1'b0;
    stream_fe_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!active_s) begin
          fsm_nxt_s = ST_RUN;
        end else if (s_axis_tvalid) begin
          stream_rgb_s = s_axis_tdata;
          if (s_axis_tlast && !last_px_s) begin
            stream_fe_s = 1'b1;
            fsm_nxt_s   = ST_WAIT;
          end else if (!s_axis_tlast && last_px_s) begin
            stream_fe_s = 1'b1;
            fsm_nxt_s   = ST_FLUSH;
          end else begin
            fsm_nxt_s = ST_RUN;
          end
        end else begin
          stream_uf_s = 1'b1;
          if (last_px_s) begin
            stream_fe_s = 1'b1;
            fsm_nxt_s   = ST_FLUSH;
          end else begin
            fsm_nxt_s = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (handshake_s && s_axis_tlast) begin
          fsm_nxt_s = ST_WAIT;
        end else begin
          fsm_nxt_s = ST_FLUSH;
        end
      end
      ST_WAIT: fsm_nxt_s = ST_WAIT;
      default: fsm_nxt_s = ST_RUN;
    endcase
  end

  // WAIT releases on the wrap so pixel 0 of the next frame is fetched
`ifdef VIDEO_TEST_PATTERN_EN
  logic [9:0] bar_w_s;
  logic [2:0] bar_idx_s;
  assign bar_w_s     = H_ACT_W / 10'd8;
  assign bar_idx_s   = 3'(h_cnt_s / bar_w_s);
  assign state_d     = pattern_en ? ST_WAIT :
                       ((frame_wrap_s && (fsm_nxt_s == ST_WAIT)) ? ST_RUN : fsm_nxt_s);
  assign rgb_d       = pattern_en ? (active_s ? bar_colour(bar_idx_s) : 24'h000000) : stream_rgb_s;
  assign underflow_d = stream_uf_s && !pattern_en;
  assign frame_err_d = stream_fe_s && !pattern_en;
`else
  assign state_d     = (frame_wrap_s && (fsm_nxt_s == ST_WAIT)) ? ST_RUN : fsm_nxt_s;
  assign rgb_d       = stream_rgb_s;
  assign underflow_d = stream_uf_s;
  assign frame_err_d = stream_fe_s;
`endif

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      rgb_q       <= 24'h000000;
      blank_q     <= 1'b1;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rgb_q       <= rgb_d;
      blank_q     <= ~active_s;
      hsync_q     <= hs_raw_s ? HS_POL : ~HS_POL;
      vsync_q     <= vs_raw_s ? VS_POL : ~VS_POL;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];
  assign blank     = blank_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign underflow = underflow_q;
  assign frame_err = frame_err_q;

endmodule
